// File: rtl/fft_stage_sequencer_pkg.sv
// fft_stage_sequencer_pkg
//   Shared definitions for the FFT stage sequencer:
//     - state_t       : FSM state encoding (also exported on state_out)
//     - MODE_A2B/B2A  : ping-pong direction of a stage_to_stage pass
//     - clog2()       : constant-evaluable ceiling log2 for parameter math
package fft_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        STATE_IN  = 2'd0,
        STATE_SS  = 2'd1,
        STATE_OUT = 2'd2
    } state_t;

    localparam logic MODE_A2B = 1'b0;
    localparam logic MODE_B2A = 1'b1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if
//   Start/finished handshake bundle between the sequencer and the three
//   datapath blocks (buffer_BB_to_stage, stage_to_stage, stage_to_out).
//   Parameter:
//     LOG_N : width of the stage index
//   Modports:
//     master : the sequencer (drives starts, index, mode, bank)
//     slave  : the datapath side (drives finished pulses)
interface fft_stage_sequencer_if #(
    parameter int LOG_N = 4
);
    logic             b2s_start;
    logic             b2s_finished;
    logic             ss_start;
    logic [LOG_N-1:0] ss_index;
    logic             ss_mode;
    logic             ss_finished;
    logic             s2o_start;
    logic             s2o_bank;
    logic             s2o_finished;

    modport master (
        output b2s_start, ss_start, ss_index, ss_mode, s2o_start, s2o_bank,
        input  b2s_finished, ss_finished, s2o_finished
    );

    modport slave (
        input  b2s_start, ss_start, ss_index, ss_mode, s2o_start, s2o_bank,
        output b2s_finished, ss_finished, s2o_finished
    );
endinterface

// File: rtl/fft_seq_watchdog.sv
// fft_seq_watchdog
//   Dwell-time watchdog for the sequencer FSM. Counts clock edges spent in
//   the current state and raises timeout on the WD_CYCLES-th edge after the
//   edge that entered that state (re-entry via reset or timeout counts).
//   Only instantiated when FFT_SEQ_WATCHDOG_EN is defined.
//   Ports:
//     clk     : system clock
//     rst     : synchronous active-high reset
//     state   : current (registered) FSM state
//     timeout : combinational, high for the edge on which the FSM must abort
module fft_seq_watchdog
    import fft_stage_sequencer_pkg::*;
#(
    parameter int WD_CYCLES = 64
) (
    input  logic   clk,
    input  logic   rst,
    input  state_t state,
    output logic   timeout
);
    localparam int CW = clog2(WD_CYCLES + 1);

    logic [CW-1:0] count;
    state_t        last_state;
    logic          changed;

    assign changed = (state != last_state);
    assign timeout = !changed && (count == CW'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            last_state <= STATE_IN;
        end else begin
            last_state <= state;
            // The edge that reveals a change already counts as one dwell edge.
            if (changed) begin
                count <= CW'(1);
            end else if (timeout) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Control FSM for a multi-stage in-place FFT: fill stage A from the input
//   buffer, run N_STAGES stage_to_stage passes ping-ponging A<->B, then drain
//   the bank holding the result. Counts completed frames and flags protocol
//   errors (finished pulses that do not match the current state).
//   Optional: define FFT_SEQ_WATCHDOG_EN to add a dwell watchdog
//   (parameter WD_CYCLES) that aborts the frame back to IN on timeout.
//   Ports:
//     clk         : system clock
//     rst         : synchronous active-high reset
//     bus         : start/finished handshake (master side)
//     frame_count : completed frames, wraps
//     state_out   : current state (0 IN, 1 SS, 2 OUT)
//     error       : sticky protocol/timeout error, cleared by rst only
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int N           = 16,
    parameter int LOG_N       = clog2(N),
    parameter int N_STAGES    = 4,
    parameter int FIRST_STAGE = 0,
    parameter int FCWIDTH     = 16
`ifdef FFT_SEQ_WATCHDOG_EN
    ,
    parameter int WD_CYCLES   = 4 * N
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.master bus,
    output logic [FCWIDTH-1:0]    frame_count,
    output logic [1:0]            state_out,
    output logic                  error
);
    localparam int PCW = clog2(N_STAGES + 1);

    state_t         state;
    logic [PCW-1:0] pass_cnt;
    logic [PCW-1:0] pass_next;
    logic           wd_timeout;
    logic           b2s_fin;
    logic           ss_fin;
    logic           s2o_fin;

    assign b2s_fin   = bus.b2s_finished;
    assign ss_fin    = bus.ss_finished;
    assign s2o_fin   = bus.s2o_finished;
    assign pass_next = pass_cnt + PCW'(1);
    assign state_out = state;

`ifdef FFT_SEQ_WATCHDOG_EN
    fft_seq_watchdog #(
        .WD_CYCLES (WD_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .timeout (wd_timeout)
    );
`else
    assign wd_timeout = 1'b0;
`endif

    // NOTE: all state and outputs are registered here with non-blocking
    // assignments so every reader sees the pre-edge values; the default-low
    // start assignments at the top are then overridden later in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= STATE_IN;
            bus.b2s_start <= 1'b1;
            bus.ss_start  <= 1'b0;
            bus.s2o_start <= 1'b0;
            bus.ss_index  <= LOG_N'(FIRST_STAGE);
            bus.ss_mode   <= MODE_A2B;
            bus.s2o_bank  <= 1'b0;
            pass_cnt      <= '0;
            frame_count   <= '0;
            error         <= 1'b0;
        end else begin
            bus.b2s_start <= 1'b0;
            bus.ss_start  <= 1'b0;
            bus.s2o_start <= 1'b0;

            if (wd_timeout) begin
                error         <= 1'b1;
                state         <= STATE_IN;
                bus.b2s_start <= 1'b1;
            end else begin
                case (state)
                    STATE_IN: begin
                        if (ss_fin || s2o_fin) begin
                            error <= 1'b1;
                        end
                        if (b2s_fin) begin
                            bus.ss_start <= 1'b1;
                            bus.ss_index <= LOG_N'(FIRST_STAGE);
                            bus.ss_mode  <= MODE_A2B;
                            pass_cnt     <= '0;
                            state        <= STATE_SS;
                        end
                    end

                    STATE_SS: begin
                        if (b2s_fin || s2o_fin) begin
                            error <= 1'b1;
                        end
                        if (ss_fin) begin
                            pass_cnt <= pass_next;
                            if (pass_next == PCW'(N_STAGES)) begin
                                // Result sits in the destination of the last pass.
                                bus.s2o_bank  <= ~bus.ss_mode;
                                bus.s2o_start <= 1'b1;
                                state         <= STATE_OUT;
                            end else begin
                                bus.ss_index <= bus.ss_index + LOG_N'(1);
                                bus.ss_mode  <= (bus.ss_mode == MODE_A2B) ? MODE_B2A : MODE_A2B;
                                bus.ss_start <= 1'b1;
                            end
                        end
                    end

                    STATE_OUT: begin
                        if (b2s_fin || ss_fin) begin
                            error <= 1'b1;
                        end
                        if (s2o_fin) begin
                            frame_count   <= frame_count + FCWIDTH'(1);
                            bus.b2s_start <= 1'b1;
                            state         <= STATE_IN;
                        end
                    end

                    default: begin
                        // Encoding 3 is unreachable in normal operation; recover.
                        error         <= 1'b1;
                        state         <= STATE_IN;
                        bus.b2s_start <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
    localparam int LOG_N = 4;
    localparam int WD    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.LOG_N(LOG_N)) if0 ();
    fft_stage_sequencer_if #(.LOG_N(LOG_N)) if1 ();

    logic [15:0] fc [2];
    logic [1:0]  st [2];
    logic        er [2];

    // dut 0: 4 passes from stage 0; dut 1: 3 passes from stage 1
    fft_stage_sequencer #(
        .N(16), .LOG_N(LOG_N), .N_STAGES(4), .FIRST_STAGE(0), .FCWIDTH(16)
`ifdef FFT_SEQ_WATCHDOG_EN
        , .WD_CYCLES(WD)
`endif
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0),
        .frame_count(fc[0]), .state_out(st[0]), .error(er[0])
    );

    fft_stage_sequencer #(
        .N(16), .LOG_N(LOG_N), .N_STAGES(3), .FIRST_STAGE(1), .FCWIDTH(16)
`ifdef FFT_SEQ_WATCHDOG_EN
        , .WD_CYCLES(WD)
`endif
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1),
        .frame_count(fc[1]), .state_out(st[1]), .error(er[1])
    );

    // ---------------- input drive / output views ----------------
    logic i_bf [2];
    logic i_sf [2];
    logic i_of [2];
    assign if0.b2s_finished = i_bf[0];
    assign if0.ss_finished  = i_sf[0];
    assign if0.s2o_finished = i_of[0];
    assign if1.b2s_finished = i_bf[1];
    assign if1.ss_finished  = i_sf[1];
    assign if1.s2o_finished = i_of[1];

    logic       o_b2s [2];
    logic       o_ss  [2];
    logic       o_s2o [2];
    logic       o_mode[2];
    logic       o_bank[2];
    logic [3:0] o_idx [2];
    assign o_b2s[0] = if0.b2s_start;  assign o_b2s[1] = if1.b2s_start;
    assign o_ss[0]  = if0.ss_start;   assign o_ss[1]  = if1.ss_start;
    assign o_s2o[0] = if0.s2o_start;  assign o_s2o[1] = if1.s2o_start;
    assign o_mode[0]= if0.ss_mode;    assign o_mode[1]= if1.ss_mode;
    assign o_bank[0]= if0.s2o_bank;   assign o_bank[1]= if1.s2o_bank;
    assign o_idx[0] = if0.ss_index;   assign o_idx[1] = if1.ss_index;

    function automatic int ns(input int d);
        return (d == 0) ? 4 : 3;
    endfunction
    function automatic int fs(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbering follows the published state_out encoding:
    // 0 = filling, 1 = passes, 2 = draining. m_pass = passes completed.
    int          m_phase [2];
    int          m_pass  [2];
    int          m_dwell [2];
    int unsigned m_frames[2];
    bit          m_err   [2];
    bit          e_b2s   [2];
    bit          e_ss    [2];
    bit          e_s2o   [2];

    // Advance the model by one clock edge given the finished pulses {s2o, ss, b2s}.
    function automatic void model_step(input int d, input bit r, input logic [2:0] fin);
        int prev;
        prev     = m_phase[d];
        e_b2s[d] = 1'b0;
        e_ss[d]  = 1'b0;
        e_s2o[d] = 1'b0;
        if (r) begin
            m_phase[d]  = 0;
            m_pass[d]   = 0;
            m_frames[d] = 0;
            m_err[d]    = 1'b0;
            m_dwell[d]  = 0;
            e_b2s[d]    = 1'b1;
            return;
        end
`ifdef FFT_SEQ_WATCHDOG_EN
        m_dwell[d]++;
        if (m_dwell[d] == WD) begin
            m_err[d]   = 1'b1;
            m_phase[d] = 0;
            m_dwell[d] = 0;
            e_b2s[d]   = 1'b1;
            return;
        end
`endif
        if ((fin & ~(3'b001 << m_phase[d])) != 3'b000) m_err[d] = 1'b1;
        if (fin[m_phase[d]]) begin
            if (m_phase[d] == 0) begin
                m_phase[d] = 1;
                m_pass[d]  = 0;
                e_ss[d]    = 1'b1;
            end else if (m_phase[d] == 1) begin
                m_pass[d]++;
                if (m_pass[d] == ns(d)) begin
                    m_phase[d] = 2;
                    e_s2o[d]   = 1'b1;
                end else begin
                    e_ss[d] = 1'b1;
                end
            end else begin
                m_frames[d]++;
                m_phase[d] = 0;
                e_b2s[d]   = 1'b1;
            end
        end
        if (m_phase[d] != prev) m_dwell[d] = 0;
    endfunction

    // ---------------- per-cycle compare process ----------------
    bit chk_on = 1'b0;
    int obs_ss[$];    // d*1000 + index*10 + mode, for every observed ss_start
    int obs_bank[$];  // d*10 + bank, for every observed s2o_start

    always begin
        @(posedge clk);
        #1;
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                check("b2s_start",   d, 32'(o_b2s[d]), int'(e_b2s[d]));
                check("ss_start",    d, 32'(o_ss[d]),  int'(e_ss[d]));
                check("s2o_start",   d, 32'(o_s2o[d]), int'(e_s2o[d]));
                check("state_out",   d, 32'(st[d]),    m_phase[d]);
                check("frame_count", d, 32'(fc[d]),    int'(m_frames[d] % 65536));
                check("error",       d, 32'(er[d]),    int'(m_err[d]));
                if (e_ss[d]) begin
                    check("ss_index", d, 32'(o_idx[d]),  (fs(d) + m_pass[d]) % 16);
                    check("ss_mode",  d, 32'(o_mode[d]), m_pass[d] % 2);
                end
                if (e_s2o[d]) check("s2o_bank", d, 32'(o_bank[d]), ((ns(d) - 1) % 2) ^ 1);
                if (o_ss[d] === 1'b1)  obs_ss.push_back(d * 1000 + int'(o_idx[d]) * 10 + int'(o_mode[d]));
                if (o_s2o[d] === 1'b1) obs_bank.push_back(d * 10 + int'(o_bank[d]));
            end
        end
    end

    // ---------------- stimulus ----------------
    bit         rst_req = 1'b1;
    bit         auto_en [2] = '{1'b1, 1'b1};
    bit         inj_en  = 1'b0;
    logic [2:0] frc     [2] = '{3'b000, 3'b000};
    int         pend    [2] = '{-1, -1};
    int         kind    [2] = '{0, 0};

    // One clock: drive inputs on the falling edge, step the model, return
    // just after the rising edge (after the compare process has sampled).
    task automatic cycle();
        @(negedge clk);
        rst = rst_req;
        for (int d = 0; d < 2; d++) begin
            logic [2:0] fin;
            fin = 3'b000;
            if (rst_req) begin
                pend[d] = -1;
            end else begin
                if (auto_en[d]) begin
                    if (pend[d] < 0) begin
                        pend[d] = $urandom_range(5, 0);
                        kind[d] = m_phase[d];
                    end
                    if (pend[d] == 0) begin
                        fin[kind[d]] = 1'b1;
                        pend[d] = -1;
                    end else begin
                        pend[d]--;
                    end
                    if (inj_en && $urandom_range(47, 0) == 0) fin[$urandom_range(2, 0)] = 1'b1;
                end
                fin = fin | frc[d];
            end
            frc[d]  = 3'b000;
            i_bf[d] = fin[0];
            i_sf[d] = fin[1];
            i_of[d] = fin[2];
            model_step(d, rst_req, fin);
        end
        chk_on = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        rst_req = 1'b1;
        repeat (cycles) cycle();
        rst_req = 1'b0;
    endtask

    initial begin
        int done [2];
        int exp_idx0 [4];
        int exp_idx1 [3];
        int got;
        int seen;
        for (int d = 0; d < 2; d++) begin
            i_bf[d] = 1'b0; i_sf[d] = 1'b0; i_of[d] = 1'b0;
        end

        // Reset release: b2s_start high in every reset cycle.
        rst_req = 1'b1;
        repeat (3) begin
            cycle();
            for (int d = 0; d < 2; d++) begin
                check("rst b2s_start", d, 32'(o_b2s[d]), 1);
                check("rst state",     d, 32'(st[d]),    0);
                check("rst error",     d, 32'(er[d]),    0);
                check("rst frames",    d, 32'(fc[d]),    0);
            end
        end
        rst_req = 1'b0;
        obs_ss.delete();
        obs_bank.delete();

        // First frame on both: hand-computed pass sequence pins the model.
        done = '{0, 0};
        for (int c = 0; c < 400 && !(done[0] != 0 && done[1] != 0); c++) begin
            cycle();
            for (int d = 0; d < 2; d++) begin
                if (done[d] == 0 && fc[d] !== 16'd0) begin
                    check("frame1 count", d, 32'(fc[d]),    1);
                    check("frame1 b2s",   d, 32'(o_b2s[d]), 1);
                    done[d] = 1;
                end
            end
        end
        for (int d = 0; d < 2; d++) check("frame1 reached", d, 32'(done[d]), 1);

        exp_idx0 = '{0, 1, 2, 3};
        exp_idx1 = '{1, 2, 3};
        for (int d = 0; d < 2; d++) begin
            seen = 0;
            foreach (obs_ss[i]) begin
                if (obs_ss[i] / 1000 == d && seen < ns(d)) begin
                    got = obs_ss[i] % 1000;
                    check("literal index", d, 32'(got / 10),
                          (d == 0) ? exp_idx0[seen] : exp_idx1[seen]);
                    check("literal mode",  d, 32'(got % 10), seen % 2);
                    seen++;
                end
            end
            check("literal pass count", d, 32'(seen), ns(d));
            seen = 0;
            foreach (obs_bank[i]) begin
                if (obs_bank[i] / 10 == d && seen == 0) begin
                    check("literal bank", d, 32'(obs_bank[i] % 10), (d == 0) ? 0 : 1);
                    seen = 1;
                end
            end
            check("literal bank seen", d, 32'(seen), 1);
        end

        // Clean random traffic.
        repeat (2500) cycle();

        // Protocol error on dut0 (ss_finished in IN); simultaneous pulses on dut1.
        do_reset(1);
        auto_en[0] = 1'b0;
        auto_en[1] = 1'b0;
        cycle();
        frc[0] = 3'b010;
        frc[1] = 3'b101;
        cycle();
        check("proto error",      0, 32'(er[0]),   1);
        check("proto state",      0, 32'(st[0]),   0);
        check("simul ss_start",   1, 32'(o_ss[1]), 1);
        check("simul state",      1, 32'(st[1]),   1);
        check("simul error",      1, 32'(er[1]),   1);
        repeat (5) cycle();
        auto_en[0] = 1'b1;
        auto_en[1] = 1'b1;
        repeat (300) cycle();
        check("sticky error", 0, 32'(er[0]), 1);
        check("sticky error", 1, 32'(er[1]), 1);

        // Random traffic with stray pulses injected.
        do_reset(2);
        inj_en = 1'b1;
        repeat (2000) cycle();
        inj_en = 1'b0;

        // Reset clears error; clean traffic keeps it clear.
        do_reset(2);
        repeat (300) cycle();
        check("error cleared", 0, 32'(er[0]), 0);
        check("error cleared", 1, 32'(er[1]), 0);

        // Hold dut0 in SS with no ss_finished.
        do_reset(1);
        auto_en[0] = 1'b0;
        cycle();
        frc[0] = 3'b001;
        cycle();
        check("hold enter SS", 0, 32'(st[0]), 1);
`ifdef FFT_SEQ_WATCHDOG_EN
        repeat (WD - 1) cycle();
        check("wd pre state",  0, 32'(st[0]), 1);
        check("wd pre error",  0, 32'(er[0]), 0);
        cycle();
        check("wd state",      0, 32'(st[0]),    0);
        check("wd error",      0, 32'(er[0]),    1);
        check("wd b2s_start",  0, 32'(o_b2s[0]), 1);
        check("wd frames",     0, 32'(fc[0]),    0);
`else
        repeat (100) cycle();
        check("hold state",    0, 32'(st[0]), 1);
        check("hold error",    0, 32'(er[0]), 0);
`endif
        auto_en[0] = 1'b1;
        repeat (50) cycle();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
